// File: rtl/board_pixel_fetch_if.sv
// Signal bundle between the VGA timing/game-logic side and board_pixel_fetch.
// The master drives pixel coordinates, writes and clear requests; the slave returns pixel data and status.
interface board_pixel_fetch_if;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       pix_active;
   logic       hsync_in;
   logic       vsync_in;
   logic       wr_valid;
   logic       wr_ready;
   logic [3:0] wr_row;
   logic [3:0] wr_col;
   logic [1:0] wr_value;
   logic       wr_err;
   logic       clear_req;
   logic       clear_busy;
   logic       clear_done;
   logic [5:0] local_v;
   logic [5:0] local_h;
   logic [1:0] cell_value;
   logic       out_active;
   logic       hsync_out;
   logic       vsync_out;

   modport master (
      output pix_x, pix_y, pix_active, hsync_in, vsync_in,
      output wr_valid, wr_row, wr_col, wr_value, clear_req,
      input  wr_ready, wr_err, clear_busy, clear_done,
      input  local_v, local_h, cell_value, out_active, hsync_out, vsync_out
   );

   modport slave (
      input  pix_x, pix_y, pix_active, hsync_in, vsync_in,
      input  wr_valid, wr_row, wr_col, wr_value, clear_req,
      output wr_ready, wr_err, clear_busy, clear_done,
      output local_v, local_h, cell_value, out_active, hsync_out, vsync_out
   );
endinterface

// File: rtl/board_pixel_fetch.sv
// Splits pixel coordinates into 64x64 board cells and fetches the cell value; 2-clock latency, never stalls.
// Owns board storage with a write port (wr_ready low while the bulk-clear sequencer runs).
module board_pixel_fetch #(
   parameter int COLS = 10,
   parameter int ROWS = 7
) (
   input logic             clk,
   input logic             rst_n,
   board_pixel_fetch_if.slave bus
);
   localparam int N  = ROWS * COLS;
   localparam int IW = $clog2(N);
   localparam logic [3:0]    ROWS_L = 4'(ROWS);
   localparam logic [3:0]    COLS_L = 4'(COLS);
   localparam logic [IW-1:0] LAST   = IW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   function automatic logic [IW-1:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
      return IW'(r) * IW'(COLS) + IW'(c);
   endfunction

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          wr_ready_q, wr_ready_d;
   logic          clear_busy_q, clear_busy_d;
   logic          clear_done_q, clear_done_d;
   logic          wr_err_q, wr_err_d;
   logic [1:0]    board_q [N];
   logic [1:0]    board_d [N];

   logic [5:0]    s1_h_q, s1_h_d, s1_v_q, s1_v_d;
   logic [3:0]    s1_row_q, s1_row_d, s1_col_q, s1_col_d;
   logic          s1_act_q, s1_act_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
   logic [5:0]    local_h_q, local_h_d, local_v_q, local_v_d;
   logic [1:0]    cell_value_q, cell_value_d;
   logic          out_active_q, out_active_d, hsync_out_q, hsync_out_d, vsync_out_q, vsync_out_d;

   logic wr_accept, wr_in_range, rd_ok;

   assign wr_accept   = bus.wr_valid && wr_ready_q;
   assign wr_in_range = (bus.wr_row < ROWS_L) && (bus.wr_col < COLS_L);
   assign rd_ok       = s1_act_q && (s1_row_q < ROWS_L) && (s1_col_q < COLS_L);

   always_comb begin
      board_d  = board_q;
      state_d  = state_q;
      idx_d    = idx_q;
      wr_err_d = wr_accept && !wr_in_range;

      if (wr_accept && wr_in_range) begin
         board_d[cell_idx(bus.wr_row, bus.wr_col)] = bus.wr_value;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.clear_req) begin
               state_d = S_CLEAR;
               idx_d   = '0;
            end
         end
         S_CLEAR: begin
            board_d[idx_q] = 2'b00;
            if (idx_q == LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      wr_ready_d   = (state_d == S_IDLE);
      clear_busy_d = (state_d == S_CLEAR);
      clear_done_d = (state_d == S_DONE);
   end

   // Stage 2 reads board_q, so a write landing on the same edge is seen one pixel later.
   always_comb begin
      s1_h_d       = bus.pix_x[5:0];
      s1_v_d       = bus.pix_y[5:0];
      s1_col_d     = bus.pix_x[9:6];
      s1_row_d     = bus.pix_y[9:6];
      s1_act_d     = bus.pix_active;
      s1_hs_d      = bus.hsync_in;
      s1_vs_d      = bus.vsync_in;
      local_h_d    = s1_h_q;
      local_v_d    = s1_v_q;
      cell_value_d = rd_ok ? board_q[cell_idx(s1_row_q, s1_col_q)] : 2'b00;
      out_active_d = s1_act_q;
      hsync_out_d  = s1_hs_q;
      vsync_out_d  = s1_vs_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         wr_ready_q   <= 1'b1;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
         wr_err_q     <= 1'b0;
         for (int i = 0; i < N; i++) begin
            board_q[i] <= 2'b00;
         end
         s1_h_q       <= '0;
         s1_v_q       <= '0;
         s1_row_q     <= '0;
         s1_col_q     <= '0;
         s1_act_q     <= 1'b0;
         s1_hs_q      <= 1'b1;
         s1_vs_q      <= 1'b1;
         local_h_q    <= '0;
         local_v_q    <= '0;
         cell_value_q <= 2'b00;
         out_active_q <= 1'b0;
         hsync_out_q  <= 1'b1;
         vsync_out_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         wr_ready_q   <= wr_ready_d;
         clear_busy_q <= clear_busy_d;
         clear_done_q <= clear_done_d;
         wr_err_q     <= wr_err_d;
         board_q      <= board_d;
         s1_h_q       <= s1_h_d;
         s1_v_q       <= s1_v_d;
         s1_row_q     <= s1_row_d;
         s1_col_q     <= s1_col_d;
         s1_act_q     <= s1_act_d;
         s1_hs_q      <= s1_hs_d;
         s1_vs_q      <= s1_vs_d;
         local_h_q    <= local_h_d;
         local_v_q    <= local_v_d;
         cell_value_q <= cell_value_d;
         out_active_q <= out_active_d;
         hsync_out_q  <= hsync_out_d;
         vsync_out_q  <= vsync_out_d;
      end
   end

   assign bus.wr_ready   = wr_ready_q;
   assign bus.wr_err     = wr_err_q;
   assign bus.clear_busy = clear_busy_q;
   assign bus.clear_done = clear_done_q;
   assign bus.local_h    = local_h_q;
   assign bus.local_v    = local_v_q;
   assign bus.cell_value = cell_value_q;
   assign bus.out_active = out_active_q;
   assign bus.hsync_out  = hsync_out_q;
   assign bus.vsync_out  = vsync_out_q;
endmodule

// File: tb/tb_board_pixel_fetch.sv
// Directed bench for board_pixel_fetch: pixel pipeline, write port, range errors, bulk clear, collisions and reset.
module tb_board_pixel_fetch;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;

   board_pixel_fetch_if bus ();

   board_pixel_fetch #(.COLS(10), .ROWS(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic wr(input logic [3:0] r, input logic [3:0] c, input logic [1:0] v);
      bus.wr_valid = 1'b1;
      bus.wr_row   = r;
      bus.wr_col   = c;
      bus.wr_value = v;
      step();
      bus.wr_valid = 1'b0;
   endtask

   task automatic rd(input string tag, input int x, input int y, input logic [1:0] exp);
      bus.pix_x      = 10'(x);
      bus.pix_y      = 10'(y);
      bus.pix_active = 1'b1;
      step();
      step();
      chk(tag, 32'(bus.cell_value), 32'(exp));
      bus.pix_active = 1'b0;
   endtask

   initial begin
      int  busy_cnt;
      logic bad_ready, bad_err, done_seen;

      bus.pix_x = '0; bus.pix_y = '0; bus.pix_active = 1'b0;
      bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
      bus.wr_valid = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_value = '0;
      bus.clear_req = 1'b0;

      // reset state
      step(); step();
      chk("rst_local_h", 32'(bus.local_h), 0);
      chk("rst_local_v", 32'(bus.local_v), 0);
      chk("rst_cell", 32'(bus.cell_value), 0);
      chk("rst_active", 32'(bus.out_active), 0);
      chk("rst_hsync", 32'(bus.hsync_out), 1);
      chk("rst_vsync", 32'(bus.vsync_out), 1);
      chk("rst_err", 32'(bus.wr_err), 0);
      chk("rst_busy", 32'(bus.clear_busy), 0);
      chk("rst_done", 32'(bus.clear_done), 0);
      rst_n = 1'b1;
      step();
      chk("rst_ready", 32'(bus.wr_ready), 1);

      // basic coordinate split and 2-cycle alignment
      bus.pix_x = 10'd70; bus.pix_y = 10'd130; bus.pix_active = 1'b1;
      bus.hsync_in = 1'b0; bus.vsync_in = 1'b1;
      step();
      chk("lat1_hsync", 32'(bus.hsync_out), 1);
      chk("lat1_active", 32'(bus.out_active), 0);
      bus.vsync_in = 1'b0;
      step();
      chk("p_local_h", 32'(bus.local_h), 6);
      chk("p_local_v", 32'(bus.local_v), 2);
      chk("p_cell", 32'(bus.cell_value), 0);
      chk("p_active", 32'(bus.out_active), 1);
      chk("p_hsync", 32'(bus.hsync_out), 0);
      chk("p_vsync", 32'(bus.vsync_out), 1);
      step();
      chk("p_vsync2", 32'(bus.vsync_out), 0);
      bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.pix_active = 1'b0;

      // write (2,1)=01 then stream pixels 64..128 on line 128
      wr(4'd2, 4'd1, 2'b01);
      chk("wr_ok_err", 32'(bus.wr_err), 0);
      bus.pix_y = 10'd128; bus.pix_active = 1'b1;
      for (int i = 0; i <= 65; i++) begin
         if (i <= 64) bus.pix_x = 10'(64 + i);
         step();
         if (i >= 1) begin
            chk($sformatf("stream_cell_x%0d", 63 + i), 32'(bus.cell_value),
                (63 + i < 128) ? 32'd1 : 32'd0);
            chk($sformatf("stream_h_x%0d", 63 + i), 32'(bus.local_h), 32'((63 + i) % 64));
         end
      end
      bus.pix_active = 1'b0;

      // out-of-range writes
      wr(4'd7, 4'd0, 2'b01);
      chk("oor_row_err", 32'(bus.wr_err), 1);
      step();
      chk("oor_row_err_clr", 32'(bus.wr_err), 0);
      wr(4'd0, 4'd10, 2'b01);
      chk("oor_col_err", 32'(bus.wr_err), 1);
      step();
      chk("oor_col_err_clr", 32'(bus.wr_err), 0);
      rd("oor_keep_21", 64, 128, 2'b01);
      rd("oor_keep_10", 0, 64, 2'b00);
      rd("oor_keep_00", 0, 0, 2'b00);
      wr(4'd0, 4'd0, 2'b11);
      chk("w11_err", 32'(bus.wr_err), 0);
      rd("w11_read", 5, 7, 2'b11);

      // bulk clear
      wr(4'd6, 4'd9, 2'b10);
      rd("pre_clear_69", 639, 447, 2'b10);
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      chk("clr_busy_first", 32'(bus.clear_busy), 1);
      chk("clr_ready_first", 32'(bus.wr_ready), 0);
      bus.wr_valid = 1'b1; bus.wr_row = 4'd5; bus.wr_col = 4'd5; bus.wr_value = 2'b01;
      busy_cnt = 1; bad_ready = 1'b0; bad_err = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.wr_err) bad_err = 1'b1;
         if (!bus.clear_busy) break;
         if (bus.wr_ready) bad_ready = 1'b1;
         if (bus.clear_done) bad_ready = 1'b1;
         busy_cnt++;
      end
      chk("clr_busy_cycles", 32'(busy_cnt), 70);
      chk("clr_ready_low", 32'(bad_ready), 0);
      chk("clr_done_pulse", 32'(bus.clear_done), 1);
      chk("clr_ready_done", 32'(bus.wr_ready), 0);
      bus.wr_valid = 1'b0;
      step();
      chk("clr_done_end", 32'(bus.clear_done), 0);
      chk("clr_ready_back", 32'(bus.wr_ready), 1);
      chk("clr_no_err", 32'(bad_err), 0);
      rd("clr_00", 0, 0, 2'b00);
      rd("clr_69", 639, 447, 2'b00);
      rd("clr_55", 320, 320, 2'b00);
      rd("clr_21", 64, 128, 2'b00);

      // row 7 and inactive pixels read 00
      rd("row7", 10, 460, 2'b00);
      wr(4'd2, 4'd1, 2'b01);
      bus.pix_x = 10'd70; bus.pix_y = 10'd130; bus.pix_active = 1'b0;
      step(); step();
      chk("inactive_cell", 32'(bus.cell_value), 0);
      chk("inactive_flag", 32'(bus.out_active), 0);
      rd("active_cell", 70, 130, 2'b01);

      // write/read collision at (3,3)
      bus.pix_x = 10'd192; bus.pix_y = 10'd192; bus.pix_active = 1'b1;
      step();
      bus.pix_x = 10'd193;
      bus.wr_valid = 1'b1; bus.wr_row = 4'd3; bus.wr_col = 4'd3; bus.wr_value = 2'b10;
      step();
      bus.wr_valid = 1'b0;
      chk("coll_old", 32'(bus.cell_value), 0);
      chk("coll_old_h", 32'(bus.local_h), 0);
      step();
      chk("coll_new", 32'(bus.cell_value), 2);
      chk("coll_new_h", 32'(bus.local_h), 1);
      bus.pix_active = 1'b0;

      // reset in the middle of a clear
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      for (int i = 0; i < 30; i++) step();
      chk("mid_busy", 32'(bus.clear_busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.clear_busy), 0);
      chk("mid_rst_done", 32'(bus.clear_done), 0);
      step();
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (bus.clear_done || bus.clear_busy) done_seen = 1'b1;
      end
      chk("mid_no_done", 32'(done_seen), 0);
      chk("mid_ready", 32'(bus.wr_ready), 1);
      rd("mid_board_33", 200, 200, 2'b00);
      rd("mid_board_21", 70, 130, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
